alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legality check and FSM state type shared by the ALU issue controller and ALU.
// Rev 1.0
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// alu: registered ALU; result and Z/Y flags appear one edge after the opcode is presented.
// Rev 1.0
`default_nettype none

module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        alu_op_i,
  input  logic [DATA_W-1:0] in_1_i,
  input  logic [DATA_W-1:0] in_2_i,
  output logic [DATA_W-1:0] alu_out_o,
  output logic              z_o,
  output logic              y_o
);

  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] res_d;
  logic              y_d;
  logic              z_d;

  assign sum_w  = {1'b0, in_1_i} + {1'b0, in_2_i};
  assign diff_w = {1'b0, in_1_i} - {1'b0, in_2_i};

  // Y is carry-out for ADD and borrow for SUB; zero for all other ops.
  always_comb begin
    res_d = '0;
    y_d   = 1'b0;
    case (alu_op_i)
      OP_ADD: begin res_d = sum_w[DATA_W-1:0];  y_d = sum_w[DATA_W];  end
      OP_SUB: begin res_d = diff_w[DATA_W-1:0]; y_d = diff_w[DATA_W]; end
      OP_AND: res_d = in_1_i & in_2_i;
      OP_OR:  res_d = in_1_i | in_2_i;
      OP_XOR: res_d = in_1_i ^ in_2_i;
      OP_SHL: res_d = in_1_i << in_2_i;
      OP_SHR: res_d = in_1_i >> in_2_i;
      default: res_d = '0;
    endcase
    z_d = is_legal_op(alu_op_i) && (res_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_out_o <= '0;
      z_o       <= 1'b0;
      y_o       <= 1'b0;
    end else begin
      alu_out_o <= res_d;
      z_o       <= z_d;
      y_o       <= y_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one ALU request, issues it for one cycle, captures the result and holds the response.
// Rev 1.0
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_z_o,
  output logic              resp_y_o,
  output logic              resp_err_o,
  output logic [3:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_in_1_o,
  output logic [DATA_W-1:0] alu_in_2_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_z_i,
  input  logic              alu_y_i,
  output logic [DATA_W-1:0] op_count_o
);

  state_e            state_q;
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] alu_in_1_q;
  logic [DATA_W-1:0] alu_in_2_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_z_q;
  logic              resp_y_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] op_count_q;
  logic [DATA_W-1:0] op_count_d;

  assign op_count_d = op_count_q + 1'b1;

  // The ALU drive registers double as the request latch: loaded on accept, cleared after ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      alu_op_q     <= OP_NOP;
      alu_in_1_q   <= '0;
      alu_in_2_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_z_q     <= 1'b0;
      resp_y_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (is_legal_op(req_op_i)) begin
              alu_op_q   <= req_op_i;
              alu_in_1_q <= req_a_i;
              alu_in_2_q <= req_b_i;
              state_q    <= ST_ISSUE;
            end else begin
              resp_data_q  <= '0;
              resp_z_q     <= 1'b0;
              resp_y_q     <= 1'b0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          alu_op_q   <= OP_NOP;
          alu_in_1_q <= '0;
          alu_in_2_q <= '0;
          state_q    <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          resp_data_q  <= alu_out_i;
          resp_z_q     <= alu_z_i;
          resp_y_q     <= alu_y_i;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          op_count_q   <= op_count_d;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_z_o     = resp_z_q;
  assign resp_y_o     = resp_y_q;
  assign resp_err_o   = resp_err_q;
  assign alu_op_o     = alu_op_q;
  assign alu_in_1_o   = alu_in_1_q;
  assign alu_in_2_o   = alu_in_2_q;
  assign op_count_o   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized and directed checks of alu_issue_ctrl driving the real ALU.
// Rev 1.0
`default_nettype none

module tb_alu_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [15:0] resp_data_o;
  logic        resp_z_o;
  logic        resp_y_o;
  logic        resp_err_o;
  logic [3:0]  alu_op_o;
  logic [15:0] alu_in_1_o;
  logic [15:0] alu_in_2_o;
  logic [15:0] alu_out_w;
  logic        alu_z_w;
  logic        alu_y_w;
  logic [15:0] op_count_o;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count;

  always #5 clk_i = ~clk_i;

  alu_issue_ctrl #(.DATA_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .resp_z_o(resp_z_o), .resp_y_o(resp_y_o), .resp_err_o(resp_err_o),
    .alu_op_o(alu_op_o), .alu_in_1_o(alu_in_1_o), .alu_in_2_o(alu_in_2_o),
    .alu_out_i(alu_out_w), .alu_z_i(alu_z_w), .alu_y_i(alu_y_w),
    .op_count_o(op_count_o)
  );

  alu #(.DATA_W(16)) u_alu (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_op_i(alu_op_o), .in_1_i(alu_in_1_o), .in_2_i(alu_in_2_o),
    .alu_out_o(alu_out_w), .z_o(alu_z_w), .y_o(alu_y_w)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic [3:0] op);
    return (op == 1) || (op == 2) || (op == 3) || (op == 4) || (op == 5) || (op == 7) || (op == 8);
  endfunction

  // Reference arithmetic: Y = carry for ADD, borrow for SUB; Z = zero result.
  task automatic model_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic z, output logic y);
    int s;
    r = 0; y = 0;
    case (op)
      1: begin s = int'(a) + int'(b); r = 16'(s % 65536); y = (s >= 65536); end
      2: begin r = 16'((int'(a) - int'(b) + 65536) % 65536); y = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      7: r = (b > 15) ? 16'd0 : 16'((int'(a) * (1 << b)) % 65536);
      8: r = (b > 15) ? 16'd0 : 16'(int'(a) / (1 << b));
      default: r = 0;
    endcase
    z = (r == 0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] er;
    logic        ez, ey;
    bit          legal;
    int          guard;
    guard = 0;
    while (!req_ready_o && guard < 20) begin tick(); guard++; end
    check("req_ready_idle", req_ready_o, 1);
    check("idle_alu_nop", alu_op_o, 0);
    req_valid_i = 1; req_op_i = op; req_a_i = a; req_b_i = b;
    resp_ready_i = 1'($urandom);
    tick();
    req_valid_i = 0; req_op_i = 4'($urandom); req_a_i = 16'($urandom); req_b_i = 16'($urandom);
    legal = model_legal(op);
    if (legal) begin
      model_alu(op, a, b, er, ez, ey);
      exp_count = exp_count + 16'd1;
      check("issue_op", alu_op_o, op);
      check("issue_in1", alu_in_1_o, a);
      check("issue_in2", alu_in_2_o, b);
      check("issue_busy", req_ready_o, 0);
      check("issue_no_resp", resp_valid_o, 0);
      tick();
      check("capture_nop", alu_op_o, 0);
      check("capture_in1", alu_in_1_o, 0);
      check("capture_no_resp", resp_valid_o, 0);
      tick();
    end else begin
      er = 0; ez = 0; ey = 0;
    end
    resp_ready_i = 0;
    check("resp_valid", resp_valid_o, 1);
    check("resp_data", resp_data_o, er);
    check("resp_z", resp_z_o, ez);
    check("resp_y", resp_y_o, ey);
    check("resp_err", resp_err_o, !legal);
    check("resp_alu_nop", alu_op_o, 0);
    check("op_count", op_count_o, exp_count);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin req_valid_i = 1; req_op_i = 4'd9; end
      tick();
      check("hold_valid", resp_valid_o, 1);
      check("hold_data", resp_data_o, er);
      check("hold_err", resp_err_o, !legal);
      check("hold_ready", req_ready_o, 0);
    end
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;
    check("post_hs_valid", resp_valid_o, 0);
    check("post_hs_ready", req_ready_o, 1);
    req_valid_i = 0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    rst_i = 1; req_valid_i = 0; req_op_i = 0; req_a_i = 0; req_b_i = 0; resp_ready_i = 0;
    exp_count = 0;
    tick(); tick();
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_data", resp_data_o, 0);
    check("rst_resp_err", resp_err_o, 0);
    check("rst_alu_op", alu_op_o, 0);
    check("rst_alu_in", {alu_in_1_o, alu_in_2_o}, 0);
    check("rst_count", op_count_o, 0);
    rst_i = 0;
    check("rst_req_ready", req_ready_o, 1);

    do_op(4'd1, 16'd5, 16'd3, 0);
    do_op(4'd2, 16'd3, 16'd3, 1);
    do_op(4'd6, 16'd5, 16'd3, 2);
    do_op(4'd3, 16'hF0F0, 16'h0FF0, 5);
    do_op(4'd1, 16'hFFFF, 16'd1, 0);
    do_op(4'd8, 16'h8000, 16'd15, 0);
    do_op(4'd0, 16'd1, 16'd1, 0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if (op == 7 || op == 8) b = 16'($urandom_range(0, 17));
      do_op(op, a, b, $urandom_range(0, 3));
    end

    // Reset while in CAPTURE discards the pending operation.
    req_valid_i = 1; req_op_i = 4'd1; req_a_i = 16'd1; req_b_i = 16'd1;
    tick();
    req_valid_i = 0;
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    exp_count = 0;
    check("rstcap_valid", resp_valid_o, 0);
    check("rstcap_count", op_count_o, 0);
    check("rstcap_alu_op", alu_op_o, 0);
    check("rstcap_ready", req_ready_o, 1);

    // Reset beats a simultaneous request.
    rst_i = 1; req_valid_i = 1; req_op_i = 4'd6;
    tick();
    rst_i = 0; req_valid_i = 0;
    check("rstreq_valid", resp_valid_o, 0);
    check("rstreq_ready", req_ready_o, 1);

    do_op(4'd5, 16'h1234, 16'h00FF, 0);

    // Counter wrap from all-ones.
    #1;
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    check("preload_count", op_count_o, 16'hFFFF);
    do_op(4'd1, 16'd2, 16'd2, 0);
    check("wrap_count", op_count_o, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
